// File: rtl/scan_capture_ctrl.sv
// scan_capture_ctrl: multi-channel scan-chain capture engine.
// Raises scan enable towards the DUT, optionally waits out a start latency, then
// deserialises NCH parallel scan streams into W-bit words. It stores DEPTH words per
// channel in a frame buffer, which can be read back through a registered port.
module scan_capture_ctrl #(
  parameter int NCH       = 2,
  parameter int W         = 26,
  parameter int DEPTH     = 256,
  parameter int START_LAT = 1,
  parameter int MSB_FIRST = 0,
  parameter int DESCEND   = 1,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           scan_start_i,
  input  logic           scan_abort_i,
  input  logic [NCH-1:0] scan_bit_i,
  output logic           scan_en_o,
  output logic           busy_o,
  output logic           frame_done_o,
  output logic           frame_valid_o,
  input  logic           rd_en_i,
  input  logic [CW-1:0]  rd_ch_i,
  input  logic [AW-1:0]  rd_addr_i,
  output logic [W-1:0]   rd_data_o,
  output logic           rd_vld_o
);

  localparam int BW = $clog2(W);
  localparam int LW = (START_LAT > 1) ? $clog2(START_LAT) : 1;

  localparam logic [AW-1:0] FIRST_WORD = (DESCEND != 0) ? AW'(DEPTH - 1) : '0;
  localparam logic [AW-1:0] LAST_WORD  = (DESCEND != 0) ? '0 : AW'(DEPTH - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(W - 1);
  localparam logic [LW-1:0] LAST_LEAD  = LW'((START_LAT > 0) ? START_LAT - 1 : 0);
  localparam logic [CW:0]   NCH_L      = (CW + 1)'(NCH);

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [LW-1:0]           leadCnt_q, leadCnt_d;
  logic [BW-1:0]           bitIdx_q, bitIdx_d;
  logic [AW-1:0]           wordIdx_q, wordIdx_d;
  logic [NCH-1:0][W-1:0]   acc_q, acc_d;
  logic                    frameValid_q, frameValid_d;
  logic [W-1:0]            rdData_q;
  logic                    rdVld_q;
  logic [NCH-1:0][W-1:0]   assembled;
  logic                    wrEn;

  logic [W-1:0] frameBuf [NCH][DEPTH];

  // Word as it looks once the bit currently on the wire is folded in; this is what gets stored on the last bit of a word.
  always_comb begin
    assembled = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (MSB_FIRST != 0) begin
        assembled[ch] = {acc_q[ch][W-2:0], scan_bit_i[ch]};
      end else begin
        assembled[ch] = {scan_bit_i[ch], acc_q[ch][W-1:1]};
      end
    end
  end

  // Next-state logic: sequencing of lead-in, shifting, word/address stepping and frame status.
  always_comb begin
    state_d      = state_q;
    leadCnt_d    = leadCnt_q;
    bitIdx_d     = bitIdx_q;
    wordIdx_d    = wordIdx_q;
    acc_d        = acc_q;
    frameValid_d = frameValid_q;
    wrEn         = 1'b0;
    case (state_q)
      IDLE: begin
        leadCnt_d = '0;
        bitIdx_d  = '0;
        wordIdx_d = FIRST_WORD;
        if (scan_start_i && !scan_abort_i) begin
          frameValid_d = 1'b0;
          state_d      = (START_LAT == 0) ? SHIFT : LEAD;
        end
      end
      LEAD: begin
        if (scan_abort_i) begin
          state_d = IDLE;
        end else if (leadCnt_q == LAST_LEAD) begin
          state_d = SHIFT;
        end else begin
          leadCnt_d = leadCnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (scan_abort_i) begin
          state_d = IDLE;
        end else begin
          acc_d = assembled;
          if (bitIdx_q == LAST_BIT) begin
            wrEn      = 1'b1;
            bitIdx_d  = '0;
            wordIdx_d = (DESCEND != 0) ? wordIdx_q - 1'b1 : wordIdx_q + 1'b1;
            if (wordIdx_q == LAST_WORD) begin
              state_d = DONE;
            end
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!scan_abort_i) begin
          frameValid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and accumulator registers; everything here returns to idle on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      leadCnt_q    <= '0;
      bitIdx_q     <= '0;
      wordIdx_q    <= '0;
      acc_q        <= '0;
      frameValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      leadCnt_q    <= leadCnt_d;
      bitIdx_q     <= bitIdx_d;
      wordIdx_q    <= wordIdx_d;
      acc_q        <= acc_d;
      frameValid_q <= frameValid_d;
    end
  end

  // Frame buffer write: all channels store their assembled word at the same address; contents survive reset.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int ch = 0; ch < NCH; ch++) begin
        frameBuf[ch][wordIdx_q] <= assembled[ch];
      end
    end
  end

  // Registered readback; a same-cycle write is not visible yet, so the previous word is returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdData_q <= '0;
      rdVld_q  <= 1'b0;
    end else begin
      rdVld_q <= rd_en_i;
      if (rd_en_i) begin
        if ({1'b0, rd_ch_i} < NCH_L) begin
          rdData_q <= frameBuf[rd_ch_i][rd_addr_i];
        end else begin
          rdData_q <= '0;
        end
      end
    end
  end

  assign scan_en_o     = (state_q == LEAD) || (state_q == SHIFT);
  assign busy_o        = scan_en_o;
  assign frame_done_o  = (state_q == DONE);
  assign frame_valid_o = frameValid_q;
  assign rd_data_o     = rdData_q;
  assign rd_vld_o      = rdVld_q;

endmodule

// File: tb/tb_scan_capture_ctrl.sv
// tb_scan_capture_ctrl: two differently configured capture engines driven with
// scan streams. The streams are generated from intended word values, and readback
// is compared against a frame-buffer model kept per instance.
module tb_scan_capture_ctrl;

  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int NCYC  = W * DEPTH;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] scanStart;
  logic [1:0] scanAbort;
  logic [1:0] rdEn;
  logic [2:0] scanBitA [2];
  logic [1:0] rdChA [2];
  logic [1:0] rdAddrA [2];

  logic       scanEn0, busy0, frameDone0, frameValid0, rdVld0;
  logic       scanEn1, busy1, frameDone1, frameValid1, rdVld1;
  logic [3:0] rdData0, rdData1;

  logic [3:0] frameWords [3][DEPTH];
  logic [3:0] model [2][3][DEPTH];
  bit         known [2][3][DEPTH];
  bit         enTr [32];
  bit         doneTr [32];
  bit         validTr [32];
  logic [3:0] rdObs;
  int         tests = 0;
  int         fails = 0;

  scan_capture_ctrl #(
    .NCH(2), .W(W), .DEPTH(DEPTH), .START_LAT(1), .MSB_FIRST(0), .DESCEND(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .scan_start_i(scanStart[0]), .scan_abort_i(scanAbort[0]),
    .scan_bit_i(scanBitA[0][1:0]),
    .scan_en_o(scanEn0), .busy_o(busy0), .frame_done_o(frameDone0), .frame_valid_o(frameValid0),
    .rd_en_i(rdEn[0]), .rd_ch_i(rdChA[0][0:0]), .rd_addr_i(rdAddrA[0]),
    .rd_data_o(rdData0), .rd_vld_o(rdVld0)
  );

  scan_capture_ctrl #(
    .NCH(3), .W(W), .DEPTH(DEPTH), .START_LAT(0), .MSB_FIRST(1), .DESCEND(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .scan_start_i(scanStart[1]), .scan_abort_i(scanAbort[1]),
    .scan_bit_i(scanBitA[1]),
    .scan_en_o(scanEn1), .busy_o(busy1), .frame_done_o(frameDone1), .frame_valid_o(frameValid1),
    .rd_en_i(rdEn[1]), .rd_ch_i(rdChA[1]), .rd_addr_i(rdAddrA[1]),
    .rd_data_o(rdData1), .rd_vld_o(rdVld1)
  );

  always #5 clk = ~clk;

  function automatic int nchOf(input int d);  return (d == 0) ? 2 : 3; endfunction
  function automatic int latOf(input int d);  return (d == 0) ? 1 : 0; endfunction
  function automatic bit msbOf(input int d);  return (d == 0) ? 1'b0 : 1'b1; endfunction
  function automatic bit descOf(input int d); return (d == 0) ? 1'b1 : 1'b0; endfunction
  function automatic logic getEn(input int d);    return (d == 0) ? scanEn0 : scanEn1; endfunction
  function automatic logic getBusy(input int d);  return (d == 0) ? busy0 : busy1; endfunction
  function automatic logic getDone(input int d);  return (d == 0) ? frameDone0 : frameDone1; endfunction
  function automatic logic getValid(input int d); return (d == 0) ? frameValid0 : frameValid1; endfunction
  function automatic logic getVld(input int d);   return (d == 0) ? rdVld0 : rdVld1; endfunction
  function automatic logic [3:0] getData(input int d); return (d == 0) ? rdData0 : rdData1; endfunction

  // Runs one frame window from IDLE; cycle 0 presents start, scan bits follow after the start latency.
  task automatic drive_frame(input int d, input bit holdStart, input int abortBit, input int rdBit,
                             input logic [1:0] rdAddrIn);
    int lat;
    int b;
    int wi;
    int j;
    lat = latOf(d);
    for (int cyc = 0; cyc < lat + NCYC + 4; cyc++) begin
      enTr[cyc]    = getEn(d);
      doneTr[cyc]  = getDone(d);
      validTr[cyc] = getValid(d);
      b = cyc - 1 - lat;
      if (rdBit >= 0 && b == rdBit + 1) rdObs = getData(d);
      scanStart[d] = (cyc == 0) || holdStart;
      scanAbort[d] = (abortBit >= 0) && (b == abortBit);
      rdEn[d]      = (rdBit >= 0) && (b == rdBit);
      rdChA[d]     = 2'd0;
      rdAddrA[d]   = rdAddrIn;
      scanBitA[d]  = 3'($urandom);
      if (b >= 0 && b < NCYC) begin
        wi = b / W;
        j  = b % W;
        for (int ch = 0; ch < nchOf(d); ch++)
          scanBitA[d][ch] = msbOf(d) ? frameWords[ch][wi][W-1-j] : frameWords[ch][wi][j];
      end
      @(negedge clk);
    end
    scanStart[d] = 1'b0;
    scanAbort[d] = 1'b0;
    rdEn[d]      = 1'b0;
  endtask

  // Records in the model the first nWords words of the frame, at the address the fill order implies.
  task automatic commit_frame(input int d, input int nWords);
    int a;
    for (int n = 0; n < nWords; n++) begin
      a = descOf(d) ? DEPTH - 1 - n : n;
      for (int ch = 0; ch < nchOf(d); ch++) begin
        model[d][ch][a] = frameWords[ch][n];
        known[d][ch][a] = 1'b1;
      end
    end
  endtask

  task automatic fill_random();
    for (int ch = 0; ch < 3; ch++)
      for (int n = 0; n < DEPTH; n++)
        frameWords[ch][n] = 4'($urandom);
  endtask

  task automatic read_word(input int d, input int ch, input int addr,
                           output logic [3:0] data, output logic vld);
    rdEn[d]    = 1'b1;
    rdChA[d]   = 2'(ch);
    rdAddrA[d] = 2'(addr);
    @(negedge clk);
    data    = getData(d);
    vld     = getVld(d);
    rdEn[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++; if (getEn(d) !== 1'b0)    begin fails++; $display("[TB] FAIL reset_scan_en d%0d: got %b want 0", d, getEn(d)); end
      tests++; if (getBusy(d) !== 1'b0)  begin fails++; $display("[TB] FAIL reset_busy d%0d: got %b want 0", d, getBusy(d)); end
      tests++; if (getDone(d) !== 1'b0)  begin fails++; $display("[TB] FAIL reset_done d%0d: got %b want 0", d, getDone(d)); end
      tests++; if (getValid(d) !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid d%0d: got %b want 0", d, getValid(d)); end
      tests++; if (getVld(d) !== 1'b0)   begin fails++; $display("[TB] FAIL reset_rd_vld d%0d: got %b want 0", d, getVld(d)); end
      tests++; if (getData(d) !== 4'h0)  begin fails++; $display("[TB] FAIL reset_rd_data d%0d: got %h want 0", d, getData(d)); end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (scanEn0 !== 1'b0) begin fails++; $display("[TB] FAIL idle_after_reset: got %b want 0", scanEn0); end
  endtask

  task automatic test_single_frame();
    int enCount, doneCount, lat;
    logic [3:0] data;
    logic vld;
    lat = latOf(0);
    for (int n = 0; n < DEPTH; n++) begin
      frameWords[0][n] = 4'h1;
      frameWords[1][n] = 4'hF;
    end
    drive_frame(0, 1'b0, -1, -1, 2'd0);
    enCount = 0; doneCount = 0;
    for (int c = 0; c < lat + NCYC + 4; c++) begin enCount += int'(enTr[c]); doneCount += int'(doneTr[c]); end
    tests++; if (enCount != 17) begin fails++; $display("[TB] FAIL scan_en_cycles: got %0d want 17", enCount); end
    tests++; if (enTr[0] !== 1'b0 || enTr[1] !== 1'b1) begin fails++; $display("[TB] FAIL scan_en_rise: got %b%b want 01", enTr[0], enTr[1]); end
    tests++; if (doneCount != 1) begin fails++; $display("[TB] FAIL done_count: got %0d want 1", doneCount); end
    tests++; if (doneTr[lat + NCYC + 1] !== 1'b1) begin fails++; $display("[TB] FAIL done_timing: got %b want 1", doneTr[lat + NCYC + 1]); end
    tests++; if (validTr[lat + NCYC + 2] !== 1'b1) begin fails++; $display("[TB] FAIL frame_valid_set: got %b want 1", validTr[lat + NCYC + 2]); end
    commit_frame(0, DEPTH);
    for (int ch = 0; ch < 2; ch++)
      for (int a = 0; a < DEPTH; a++) begin
        read_word(0, ch, a, data, vld);
        tests++;
        if (vld !== 1'b1 || data !== ((ch == 0) ? 4'h1 : 4'hF)) begin
          fails++; $display("[TB] FAIL fixed_read ch%0d a%0d: got %h/%b want %h/1", ch, a, data, vld, (ch == 0) ? 4'h1 : 4'hF);
        end
      end
    @(negedge clk);
    tests++; if (rdVld0 !== 1'b0 || rdData0 !== 4'hF) begin fails++; $display("[TB] FAIL rd_hold: got %h/%b want f/0", rdData0, rdVld0); end
  endtask

  task automatic test_last_bit();
    logic [3:0] data;
    logic vld;
    fill_random();
    for (int n = 0; n < DEPTH; n++) frameWords[0][n] = 4'h8;
    drive_frame(0, 1'b0, -1, -1, 2'd0);
    commit_frame(0, DEPTH);
    for (int a = 0; a < DEPTH; a++) begin
      read_word(0, 0, a, data, vld);
      tests++; if (data !== 4'h8) begin fails++; $display("[TB] FAIL last_bit a%0d: got %h want 8", a, data); end
      read_word(0, 1, a, data, vld);
      tests++; if (data !== model[0][1][a]) begin fails++; $display("[TB] FAIL last_bit_ch1 a%0d: got %h want %h", a, data, model[0][1][a]); end
    end
  endtask

  task automatic test_msb_lat0();
    int enCount;
    logic [3:0] data;
    logic vld;
    fill_random();
    for (int n = 0; n < DEPTH; n++) frameWords[0][n] = 4'h8;
    drive_frame(1, 1'b0, -1, -1, 2'd0);
    enCount = 0;
    for (int c = 0; c < NCYC + 4; c++) enCount += int'(enTr[c]);
    tests++; if (enTr[1] !== 1'b1) begin fails++; $display("[TB] FAIL lat0_first_shift: got %b want 1", enTr[1]); end
    tests++; if (enCount != NCYC) begin fails++; $display("[TB] FAIL lat0_en_cycles: got %0d want %0d", enCount, NCYC); end
    tests++; if (doneTr[NCYC + 1] !== 1'b1) begin fails++; $display("[TB] FAIL lat0_done: got %b want 1", doneTr[NCYC + 1]); end
    commit_frame(1, DEPTH);
    for (int ch = 0; ch < 3; ch++)
      for (int a = 0; a < DEPTH; a++) begin
        read_word(1, ch, a, data, vld);
        tests++;
        if (vld !== 1'b1 || data !== model[1][ch][a] || (ch == 0 && data !== 4'h8)) begin
          fails++; $display("[TB] FAIL msb_read ch%0d a%0d: got %h/%b want %h/1", ch, a, data, vld, model[1][ch][a]);
        end
      end
    read_word(1, 3, 0, data, vld);
    tests++; if (vld !== 1'b1 || data !== 4'h0) begin fails++; $display("[TB] FAIL bad_channel: got %h/%b want 0/1", data, vld); end
  endtask

  task automatic test_addr_order();
    logic [3:0] data;
    logic [3:0] want;
    logic vld;
    for (int d = 0; d < 2; d++) begin
      fill_random();
      for (int n = 0; n < DEPTH; n++) frameWords[0][n] = 4'(n + 1);
      drive_frame(d, 1'b0, -1, -1, 2'd0);
      commit_frame(d, DEPTH);
      for (int a = 0; a < DEPTH; a++) begin
        read_word(d, 0, a, data, vld);
        want = descOf(d) ? 4'(DEPTH - a) : 4'(a + 1);
        tests++; if (data !== want) begin fails++; $display("[TB] FAIL addr_order d%0d a%0d: got %h want %h", d, a, data, want); end
      end
    end
  endtask

  task automatic test_random_frames();
    logic [3:0] data;
    logic [3:0] oldWord;
    logic vld;
    int k, a, doneCount;
    for (int it = 0; it < 3; it++)
      for (int d = 0; d < 2; d++) begin
        fill_random();
        k = int'($urandom_range(DEPTH - 1, 0));
        a = descOf(d) ? DEPTH - 1 - k : k;
        oldWord = model[d][0][a];
        frameWords[0][k] = ~oldWord;
        drive_frame(d, 1'b0, -1, k * W + W - 1, 2'(a));
        tests++; if (rdObs !== oldWord) begin fails++; $display("[TB] FAIL rd_during_write d%0d a%0d: got %h want %h", d, a, rdObs, oldWord); end
        doneCount = 0;
        for (int c = 0; c < latOf(d) + NCYC + 4; c++) doneCount += int'(doneTr[c]);
        tests++; if (doneCount != 1) begin fails++; $display("[TB] FAIL rand_done d%0d: got %0d want 1", d, doneCount); end
        commit_frame(d, DEPTH);
        for (int ch = 0; ch < nchOf(d); ch++)
          for (int ad = 0; ad < DEPTH; ad++) begin
            read_word(d, ch, ad, data, vld);
            tests++; if (data !== model[d][ch][ad]) begin fails++; $display("[TB] FAIL rand_read d%0d ch%0d a%0d: got %h want %h", d, ch, ad, data, model[d][ch][ad]); end
          end
      end
  endtask

  task automatic test_abort();
    logic [3:0] data;
    logic vld;
    int doneCount, lat, abCyc, nDone;
    lat = latOf(0);
    for (int n = 0; n < DEPTH; n++)
      for (int ch = 0; ch < 2; ch++)
        frameWords[ch][n] = ~model[0][ch][DEPTH - 1 - n];
    drive_frame(0, 1'b0, 8, -1, 2'd0);
    abCyc = 1 + lat + 8;
    doneCount = 0;
    for (int c = 0; c < lat + NCYC + 4; c++) doneCount += int'(doneTr[c]);
    tests++; if (doneCount != 0) begin fails++; $display("[TB] FAIL abort_no_done: got %0d want 0", doneCount); end
    tests++; if (enTr[abCyc] !== 1'b1 || enTr[abCyc + 1] !== 1'b0) begin fails++; $display("[TB] FAIL abort_scan_en: got %b%b want 10", enTr[abCyc], enTr[abCyc + 1]); end
    tests++; if (getValid(0) !== 1'b0) begin fails++; $display("[TB] FAIL abort_valid: got %b want 0", getValid(0)); end
    nDone = 0;
    for (int n = 0; n < DEPTH; n++) if (n * W + W - 1 < 8) nDone++;
    commit_frame(0, nDone);
    for (int ch = 0; ch < 2; ch++)
      for (int a = 0; a < DEPTH; a++) begin
        read_word(0, ch, a, data, vld);
        tests++; if (data !== model[0][ch][a]) begin fails++; $display("[TB] FAIL abort_read ch%0d a%0d: got %h want %h", ch, a, data, model[0][ch][a]); end
      end
    fill_random();
    drive_frame(0, 1'b0, -1, -1, 2'd0);
    commit_frame(0, DEPTH);
    tests++; if (doneTr[lat + NCYC + 1] !== 1'b1 || getValid(0) !== 1'b1) begin fails++; $display("[TB] FAIL restart: got %b/%b want 1/1", doneTr[lat + NCYC + 1], getValid(0)); end
  endtask

  task automatic test_abort_start_same();
    scanStart[0] = 1'b1;
    scanAbort[0] = 1'b1;
    @(negedge clk);
    scanStart[0] = 1'b0;
    scanAbort[0] = 1'b0;
    tests++; if (scanEn0 !== 1'b0) begin fails++; $display("[TB] FAIL abort_wins_en: got %b want 0", scanEn0); end
    tests++; if (frameValid0 !== 1'b1) begin fails++; $display("[TB] FAIL abort_wins_valid: got %b want 1", frameValid0); end
    @(negedge clk);
    tests++; if (scanEn0 !== 1'b0) begin fails++; $display("[TB] FAIL abort_wins_idle: got %b want 0", scanEn0); end
  endtask

  task automatic test_hold_start();
    int rises, doneCount, lat;
    lat = latOf(0);
    fill_random();
    drive_frame(0, 1'b1, -1, -1, 2'd0);
    rises = 0; doneCount = 0;
    for (int c = 1; c <= lat + NCYC + 1; c++) begin
      if (enTr[c] && !enTr[c - 1]) rises++;
      doneCount += int'(doneTr[c]);
    end
    tests++; if (rises != 1 || doneCount != 1) begin fails++; $display("[TB] FAIL hold_one_frame: got %0d/%0d want 1/1", rises, doneCount); end
    tests++; if (enTr[lat + NCYC + 2] !== 1'b0 || enTr[lat + NCYC + 3] !== 1'b1) begin
      fails++; $display("[TB] FAIL hold_relead: got %b%b want 01", enTr[lat + NCYC + 2], enTr[lat + NCYC + 3]);
    end
    commit_frame(0, DEPTH);
    scanAbort[0] = 1'b1;
    @(negedge clk);
    scanAbort[0] = 1'b0;
    tests++; if (scanEn0 !== 1'b0 || frameValid0 !== 1'b0) begin fails++; $display("[TB] FAIL hold_abort: got %b/%b want 0/0", scanEn0, frameValid0); end
  endtask

  task automatic test_async_reset();
    logic [3:0] data;
    logic vld;
    read_word(0, 1, 0, data, vld);
    scanStart[0] = 1'b1;
    @(negedge clk);
    scanStart[0] = 1'b0;
    repeat (6) begin
      scanBitA[0] = 3'($urandom);
      @(negedge clk);
    end
    tests++; if (scanEn0 !== 1'b1) begin fails++; $display("[TB] FAIL pre_reset_shift: got %b want 1", scanEn0); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (scanEn0 !== 1'b0 || busy0 !== 1'b0 || frameDone0 !== 1'b0 || frameValid0 !== 1'b0 || rdVld0 !== 1'b0 || rdData0 !== 4'h0) begin
      fails++; $display("[TB] FAIL async_reset: got en%b busy%b done%b valid%b vld%b data%h want all 0",
                        scanEn0, busy0, frameDone0, frameValid0, rdVld0, rdData0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int ch = 0; ch < 3; ch++) for (int a = 0; a < DEPTH; a++) known[0][ch][a] = 1'b0;
    fill_random();
    drive_frame(0, 1'b0, -1, -1, 2'd0);
    commit_frame(0, DEPTH);
    tests++; if (frameValid0 !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_valid: got %b want 1", frameValid0); end
    for (int ch = 0; ch < 2; ch++)
      for (int a = 0; a < DEPTH; a++) begin
        read_word(0, ch, a, data, vld);
        tests++;
        if (!known[0][ch][a] || data !== model[0][ch][a]) begin
          fails++; $display("[TB] FAIL post_reset_read ch%0d a%0d: got %h want %h", ch, a, data, model[0][ch][a]);
        end
      end
  endtask

  initial begin
    scanStart = '0;
    scanAbort = '0;
    rdEn      = '0;
    for (int d = 0; d < 2; d++) begin
      scanBitA[d] = '0;
      rdChA[d]    = '0;
      rdAddrA[d]  = '0;
      for (int ch = 0; ch < 3; ch++)
        for (int a = 0; a < DEPTH; a++) begin
          model[d][ch][a] = '0;
          known[d][ch][a] = 1'b0;
        end
    end
    test_reset();
    test_single_frame();
    test_last_bit();
    test_msb_lat0();
    test_addr_order();
    test_random_frames();
    test_abort();
    test_abort_start_same();
    test_hold_start();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
